// File: rtl/regfile_arb_pkg.sv
// Shared constants and arbitration-source encoding for the register-bank
// write arbiter.
package regfile_arb_pkg;

  localparam int DEFAULT_DATA_WIDTH    = 32;
  localparam int DEFAULT_ADDRESS_WIDTH = 4;
  localparam int DEFAULT_FIFO_DEPTH    = 2;
  localparam int DEFAULT_STARVE_LIMIT  = 4;

  // Which writer owns the bank write port in the current cycle.
  typedef enum logic [1:0] {
    ARB_NONE = 2'd0,
    ARB_WB   = 2'd1,
    ARB_MC   = 2'd2
  } arb_src_e;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Writer-side bus of the register-bank write arbiter: the writeback stage and
// the multi-cycle unit each present one valid/ready write request channel.
//
// Handshake: a transfer happens on a rising clock edge where valid && ready
// are both high. The arbiter never waits on valid to raise ready; ready only
// reflects arbiter state (starve mode for wb, FIFO occupancy for mc).
interface regfile_write_arbiter_if
  import regfile_arb_pkg::*;
#(
  parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH
) ();

  logic                     wb_valid;
  logic                     wb_ready;
  logic [ADDRESS_WIDTH-1:0] wb_address;
  logic [DATA_WIDTH-1:0]    wb_data;

  logic                     mc_valid;
  logic                     mc_ready;
  logic [ADDRESS_WIDTH-1:0] mc_address;
  logic [DATA_WIDTH-1:0]    mc_data;

  modport master (
    output wb_valid, wb_address, wb_data,
    input  wb_ready,
    output mc_valid, mc_address, mc_data,
    input  mc_ready
  );

  modport slave (
    input  wb_valid, wb_address, wb_data,
    output wb_ready,
    input  mc_valid, mc_address, mc_data,
    output mc_ready
  );

endinterface

// File: rtl/regfile_write_fifo.sv
// Small synchronous FIFO buffering multi-cycle-unit writes. Each entry is
// {address, data}; per-entry valid bits and addresses are exported so the
// parent can build the pending-write mask.
module regfile_write_fifo #(
  parameter int DEPTH  = 2,
  parameter int WIDTH  = 36,
  parameter int ADDR_W = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic                         full,
  output logic                         empty,
  output logic [WIDTH-1:0]             head_data,
  output logic [DEPTH-1:0]             entry_valid,
  output logic [DEPTH-1:0][ADDR_W-1:0] entry_address
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [PTR_W-1:0]            rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]            count_q, count_d;
  logic                        push_ok;
  logic                        pop_ok;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign push_ok   = push && !full;
  assign pop_ok    = pop && !empty;
  assign head_data = mem_q[rd_ptr_q];

  // An entry is live when its distance from the read pointer is below the count.
  always_comb begin
    entry_valid   = '0;
    entry_address = '0;
    for (int i = 0; i < DEPTH; i++) begin
      entry_valid[i]   = ({1'b0, PTR_W'(i) - rd_ptr_q} < count_q);
      entry_address[i] = mem_q[i][WIDTH-1 -: ADDR_W];
    end
  end

  // Pointer, occupancy and storage next-state.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push_ok && !pop_ok) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // FIFO state registers; reset empties the buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register bank's single write port between the writeback stage
// (primary) and the buffered multi-cycle unit (secondary), with a starvation
// guard, a registered write stage, read forwarding and a pending-write mask.
module regfile_write_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
  parameter int FIFO_DEPTH    = DEFAULT_FIFO_DEPTH,
  parameter int STARVE_LIMIT  = DEFAULT_STARVE_LIMIT
) (
  input  logic                          clk,
  input  logic                          rst_n,
  regfile_write_arbiter_if.slave        req,
  output logic                          rf_write_enable,
  output logic [ADDRESS_WIDTH-1:0]      rf_write_address,
  output logic [DATA_WIDTH-1:0]         rf_write_data,
  input  logic [ADDRESS_WIDTH-1:0]      read_address_1,
  input  logic [ADDRESS_WIDTH-1:0]      read_address_2,
  input  logic [DATA_WIDTH-1:0]         rf_read_data_1,
  input  logic [DATA_WIDTH-1:0]         rf_read_data_2,
  output logic [DATA_WIDTH-1:0]         read_data_1,
  output logic [DATA_WIDTH-1:0]         read_data_2,
  output logic [2**ADDRESS_WIDTH-1:0]   pending_mask,
  output logic                          waw_error
);

  localparam int ENTRY_W  = ADDRESS_WIDTH + DATA_WIDTH;
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

  logic                                      fifo_full;
  logic                                      fifo_empty;
  logic                                      fifo_push;
  logic                                      fifo_pop;
  logic [ENTRY_W-1:0]                        fifo_head;
  logic [FIFO_DEPTH-1:0]                     entry_valid;
  logic [FIFO_DEPTH-1:0][ADDRESS_WIDTH-1:0]  entry_address;

  logic                     starve_mode;
  logic                     wb_fire;
  logic                     mc_fire;
  arb_src_e                 arb_src;

  logic [STARVE_W-1:0]      starve_cnt_q, starve_cnt_d;
  logic                     rf_write_enable_q, rf_write_enable_d;
  logic [ADDRESS_WIDTH-1:0] rf_write_address_q, rf_write_address_d;
  logic [DATA_WIDTH-1:0]    rf_write_data_q, rf_write_data_d;
  logic                     waw_error_q, waw_error_d;

  regfile_write_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .WIDTH  (ENTRY_W),
    .ADDR_W (ADDRESS_WIDTH)
  ) u_fifo (
    .clk           (clk),
    .rst_n         (rst_n),
    .push          (fifo_push),
    .push_data     ({req.mc_address, req.mc_data}),
    .pop           (fifo_pop),
    .full          (fifo_full),
    .empty         (fifo_empty),
    .head_data     (fifo_head),
    .entry_valid   (entry_valid),
    .entry_address (entry_address)
  );

  // A buffered write that has lost STARVE_LIMIT cycles in a row gets the port.
  assign starve_mode  = !fifo_empty && (starve_cnt_q == STARVE_W'(STARVE_LIMIT));
  assign req.wb_ready = !starve_mode;
  // Ready depends on occupancy only: a full FIFO refuses even if it pops now.
  assign req.mc_ready = !fifo_full;
  assign wb_fire      = req.wb_valid && req.wb_ready;
  assign mc_fire      = req.mc_valid && req.mc_ready;
  // Register 0 is hard-wired; its writes are consumed and dropped.
  assign fifo_push    = mc_fire && (req.mc_address != '0);
  assign fifo_pop     = (arb_src == ARB_MC);

  // Pick the owner of the write port for this cycle.
  always_comb begin
    arb_src = ARB_NONE;
    if (starve_mode) begin
      arb_src = ARB_MC;
    end else if (req.wb_valid) begin
      arb_src = ARB_WB;
    end else if (!fifo_empty) begin
      arb_src = ARB_MC;
    end
  end

  // Output-stage next state; address/data hold when nothing is written.
  always_comb begin
    rf_write_enable_d  = 1'b0;
    rf_write_address_d = rf_write_address_q;
    rf_write_data_d    = rf_write_data_q;
    case (arb_src)
      ARB_WB: begin
        if (req.wb_address != '0) begin
          rf_write_enable_d  = 1'b1;
          rf_write_address_d = req.wb_address;
          rf_write_data_d    = req.wb_data;
        end
      end
      ARB_MC: begin
        rf_write_enable_d                     = 1'b1;
        {rf_write_address_d, rf_write_data_d} = fifo_head;
      end
      default: begin
        rf_write_enable_d = 1'b0;
      end
    endcase
  end

  // Count consecutive lost cycles of a non-empty FIFO, saturating at the limit.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (fifo_empty || fifo_pop) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != STARVE_W'(STARVE_LIMIT)) begin
      starve_cnt_d = starve_cnt_q + STARVE_W'(1);
    end
  end

  // One bit per register that still has a buffered write outstanding.
  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (entry_valid[i]) begin
        pending_mask[entry_address[i]] = 1'b1;
      end
    end
  end

  // Sticky flag: writeback overtaking a buffered write to the same register.
  always_comb begin
    waw_error_d = waw_error_q;
    if (wb_fire && pending_mask[req.wb_address]) begin
      waw_error_d = 1'b1;
    end
  end

  // Forward the youngest in-flight value; FIFO contents are not visible yet.
  function automatic logic [DATA_WIDTH-1:0] forward_read(
    input logic [ADDRESS_WIDTH-1:0] addr,
    input logic [DATA_WIDTH-1:0]    bank_data,
    input logic                     wb_hit,
    input logic [ADDRESS_WIDTH-1:0] wb_addr,
    input logic [DATA_WIDTH-1:0]    wb_dat,
    input logic                     st_en,
    input logic [ADDRESS_WIDTH-1:0] st_addr,
    input logic [DATA_WIDTH-1:0]    st_dat
  );
    if (addr == '0) return '0;
    if (wb_hit && (wb_addr == addr)) return wb_dat;
    if (st_en && (st_addr == addr)) return st_dat;
    return bank_data;
  endfunction

  assign read_data_1 = forward_read(read_address_1, rf_read_data_1, wb_fire,
                                    req.wb_address, req.wb_data, rf_write_enable_q,
                                    rf_write_address_q, rf_write_data_q);
  assign read_data_2 = forward_read(read_address_2, rf_read_data_2, wb_fire,
                                    req.wb_address, req.wb_data, rf_write_enable_q,
                                    rf_write_address_q, rf_write_data_q);

  assign rf_write_enable  = rf_write_enable_q;
  assign rf_write_address = rf_write_address_q;
  assign rf_write_data    = rf_write_data_q;
  assign waw_error        = waw_error_q;

  // Arbiter state registers; reset drops any write in the output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q       <= '0;
      rf_write_enable_q  <= 1'b0;
      rf_write_address_q <= '0;
      rf_write_data_q    <= '0;
      waw_error_q        <= 1'b0;
    end else begin
      starve_cnt_q       <= starve_cnt_d;
      rf_write_enable_q  <= rf_write_enable_d;
      rf_write_address_q <= rf_write_address_d;
      rf_write_data_q    <= rf_write_data_d;
      waw_error_q        <= waw_error_d;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios followed by random
// traffic, all checked against a cycle-level behavioural model that keeps the
// buffered writes in a queue and the architectural register values in an array.
module tb_regfile_write_arbiter;
  import regfile_arb_pkg::*;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;
  localparam int NREG  = 16;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  regfile_write_arbiter_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();

  logic            rf_we;
  logic [AW-1:0]   rf_wa;
  logic [DW-1:0]   rf_wd;
  logic [AW-1:0]   ra1, ra2;
  logic [DW-1:0]   rd1_bank, rd2_bank, rd1, rd2;
  logic [NREG-1:0] pmask;
  logic            waw;

  regfile_write_arbiter #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req              (bus.slave),
    .rf_write_enable  (rf_we),
    .rf_write_address (rf_wa),
    .rf_write_data    (rf_wd),
    .read_address_1   (ra1),
    .read_address_2   (ra2),
    .rf_read_data_1   (rd1_bank),
    .rf_read_data_2   (rd2_bank),
    .read_data_1      (rd1),
    .read_data_2      (rd2),
    .pending_mask     (pmask),
    .waw_error        (waw)
  );

  // Register bank environment, written by the DUT's write port.
  logic [DW-1:0] bank [NREG] = '{default: '0};
  assign rd1_bank = bank[ra1];
  assign rd2_bank = bank[ra2];
  always @(posedge clk) if (rf_we) bank[rf_wa] <= rf_wd;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t           mq[$];                         // buffered multi-cycle writes
  int            m_starve = 0;                  // consecutive lost cycles
  bit            m_waw    = 1'b0;
  bit            m_we     = 1'b0;
  logic [AW-1:0] m_wa     = '0;
  logic [DW-1:0] m_wd     = '0;
  logic [DW-1:0] arch [NREG] = '{default: '0};  // value after all granted writes
  logic [DW-1:0] arch_undo = '0;
  bit            last_mc_fire;
  bit            last_wb_ready_obs;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] a, input bit wb_fire);
    if (a == '0) return '0;
    if (wb_fire && (bus.wb_address == a)) return bus.wb_data;
    return arch[a];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input bit wv, input int wa, input logic [DW-1:0] wd,
                       input bit mv, input int ma, input logic [DW-1:0] md,
                       input int a1, input int a2);
    bus.wb_valid   = wv;
    bus.wb_address = AW'(wa);
    bus.wb_data    = wd;
    bus.mc_valid   = mv;
    bus.mc_address = AW'(ma);
    bus.mc_data    = md;
    ra1            = AW'(a1);
    ra2            = AW'(a2);
  endtask

  task automatic idle(input int a1, input int a2);
    drive(1'b0, 0, '0, 1'b0, 0, '0, a1, a2);
  endtask

  // One cycle: called at a falling edge with inputs applied.
  task automatic step();
    int            sz;
    bit            smode, e_wb_ready, e_mc_ready, wb_fire, mc_fire, pop;
    logic [NREG-1:0] e_mask;
    wr_t           e;
    #1;
    sz         = mq.size();
    smode      = (sz > 0) && (m_starve == LIMIT);
    e_wb_ready = !smode;
    e_mc_ready = (sz < DEPTH);
    e_mask     = '0;
    foreach (mq[i]) e_mask[mq[i].addr] = 1'b1;
    wb_fire    = bus.wb_valid && e_wb_ready;
    mc_fire    = bus.mc_valid && e_mc_ready;
    last_mc_fire      = mc_fire;
    last_wb_ready_obs = bus.wb_ready;

    check("wb_ready", bus.wb_ready, e_wb_ready);
    check("mc_ready", bus.mc_ready, e_mc_ready);
    check("pending_mask", pmask, e_mask);
    check("read_data_1", rd1, exp_read(ra1, wb_fire));
    check("read_data_2", rd2, exp_read(ra2, wb_fire));

    if (wb_fire && e_mask[bus.wb_address]) m_waw = 1'b1;
    pop  = smode || (!bus.wb_valid && sz > 0);
    m_we = 1'b0;
    if (pop) begin
      e    = mq.pop_front();
      m_we = 1'b1;
      m_wa = e.addr;
      m_wd = e.data;
    end else if (wb_fire && bus.wb_address != '0) begin
      m_we = 1'b1;
      m_wa = bus.wb_address;
      m_wd = bus.wb_data;
    end
    if (m_we) begin
      arch_undo  = arch[m_wa];
      arch[m_wa] = m_wd;
    end
    if (mc_fire && bus.mc_address != '0) begin
      e.addr = bus.mc_address;
      e.data = bus.mc_data;
      mq.push_back(e);
    end
    if (sz == 0 || pop) m_starve = 0;
    else if (m_starve < LIMIT) m_starve++;

    @(posedge clk);
    #1;
    check("rf_write_enable", rf_we, m_we);
    check("rf_write_address", rf_wa, m_wa);
    check("rf_write_data", rf_wd, m_wd);
    check("waw_error", waw, m_waw);
    @(negedge clk);
  endtask

  // Asynchronous reset asserted in the middle of a cycle.
  task automatic reset_mid_cycle();
    idle(0, 0);
    #2 rst_n = 1'b0;
    #1;
    if (m_we) arch[m_wa] = arch_undo;  // the staged write never reaches the bank
    mq.delete();
    m_starve = 0;
    m_waw    = 1'b0;
    m_we     = 1'b0;
    m_wa     = '0;
    m_wd     = '0;
    check("rst_rf_write_enable", rf_we, 1'b0);
    check("rst_pending_mask", pmask, '0);
    check("rst_waw_error", waw, 1'b0);
    check("rst_mc_ready", bus.mc_ready, 1'b1);
    check("rst_wb_ready", bus.wb_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int sent;
    int low_cnt;
    idle(0, 0);
    @(posedge clk);
    #1;
    check("reset_rf_write_enable", rf_we, 1'b0);
    check("reset_rf_write_address", rf_wa, '0);
    check("reset_rf_write_data", rf_wd, '0);
    check("reset_pending_mask", pmask, '0);
    check("reset_waw_error", waw, 1'b0);
    check("reset_wb_ready", bus.wb_ready, 1'b1);
    check("reset_mc_ready", bus.mc_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    // Writeback write to r5: input forward, stage forward, then bank.
    drive(1'b1, 5, 32'hDEAD_BEEF, 1'b0, 0, '0, 5, 5);
    step();
    idle(5, 0);
    step();
    idle(5, 5);
    step();
    check("tp_bank_r5", bank[5], 32'hDEAD_BEEF);

    // Contention: wb r3 and mc r7 together.
    drive(1'b1, 3, 32'h0000_0333, 1'b1, 7, 32'h0000_0777, 3, 7);
    step();
    idle(3, 7);
    step();
    idle(7, 3);
    step();

    // Starvation: r9 buffered while writeback stays busy.
    low_cnt = 0;
    drive(1'b1, 1, 32'h1111_0000, 1'b1, 9, 32'h9999_9999, 9, 1);
    step();
    for (int c = 0; c < 7; c++) begin
      drive(1'b1, 1 + (c % 3), 32'h1111_0001 + c, 1'b0, 0, '0, 9, 2);
      step();
      if (!last_wb_ready_obs) low_cnt++;
    end
    check("tp_starve_low_cycles", low_cnt, 1);

    // Backpressure: three mc writes held until accepted, wb busy throughout.
    sent = 0;
    for (int c = 0; c < 12; c++) begin
      drive(1'b1, 1 + (c % 6), 32'h2222_0000 + c, (sent < 3), 10 + sent,
            32'hB000_0000 + sent, 10, 11 + (c % 2));
      step();
      if (last_mc_fire) sent++;
    end
    check("tp_backpressure_sent", sent, 3);
    for (int c = 0; c < 3; c++) begin
      idle(12, 10);
      step();
    end

    // Register 0 is never written or queued.
    drive(1'b1, 0, 32'h1, 1'b0, 0, '0, 0, 0);
    step();
    drive(1'b0, 0, '0, 1'b1, 0, 32'h5, 0, 0);
    step();
    idle(0, 0);
    step();

    // WAW then reset with entries still queued.
    drive(1'b1, 2, 32'h0000_0202, 1'b1, 4, 32'h0000_0404, 4, 2);
    step();
    drive(1'b1, 4, 32'h0000_4444, 1'b1, 8, 32'h0000_0808, 4, 8);
    step();
    drive(1'b1, 6, 32'h0000_0606, 1'b0, 0, '0, 4, 6);
    step();
    check("tp_waw_sticky", waw, 1'b1);
    reset_mid_cycle();
    for (int c = 0; c < 3; c++) begin
      idle(4, 8);
      step();
    end

    // Random traffic on a narrow address range to force collisions.
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(0, 9) < 7, int'($urandom_range(0, 5)), $urandom,
            $urandom_range(0, 2) != 0, int'($urandom_range(0, 5)), $urandom,
            int'($urandom_range(0, 6)), int'($urandom_range(0, 6)));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
Shares the single write port of the integer register bank between two writers: the pipeline writeback stage (primary) and the multi-cycle unit (mul/div, secondary). The multi-cycle unit's writes are buffered in a small FIFO. The block drives a registered write port into the bank and forwards in-flight write data onto both decode read ports. It also exports a pending-write mask that the decoder uses for stalls.

Parameters:
DATA_WIDTH, 32, register width
ADDRESS_WIDTH, 4, register address width; bank holds 2**ADDRESS_WIDTH registers
FIFO_DEPTH, 2, multi-cycle write buffer entries; power of 2, >=2
STARVE_LIMIT, 4, consecutive cycles a non-empty FIFO may lose arbitration before it takes priority

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
wb_valid  in  1  writeback write request
wb_ready  out  1  writeback request consumed this cycle
wb_address  in  ADDRESS_WIDTH  writeback destination
wb_data  in  DATA_WIDTH  writeback data
mc_valid  in  1  multi-cycle write request
mc_ready  out  1  FIFO can accept
mc_address  in  ADDRESS_WIDTH  multi-cycle destination
mc_data  in  DATA_WIDTH  multi-cycle data
rf_write_enable  out  1  to bank write_enable
rf_write_address  out  ADDRESS_WIDTH  to bank write_address
rf_write_data  out  DATA_WIDTH  to bank write_data
read_address_1  in  ADDRESS_WIDTH  decode read port 1 address, also driven to bank
read_address_2  in  ADDRESS_WIDTH  decode read port 2 address, also driven to bank
rf_read_data_1  in  DATA_WIDTH  bank read_data_1
rf_read_data_2  in  DATA_WIDTH  bank read_data_2
read_data_1  out  DATA_WIDTH  forwarded read data 1
read_data_2  out  DATA_WIDTH  forwarded read data 2
pending_mask  out  2**ADDRESS_WIDTH  one bit per register with a buffered write
waw_error  out  1  sticky protocol-violation flag

Behaviour:
- Reset, asynchronous: rf_write_* = 0; FIFO empty; starve counter = 0; waw_error = 0. Consequences: mc_ready = 1, pending_mask = 0, wb_ready = 1.
- Handshakes:
  - A WB transfer occurs when wb_valid && wb_ready.
  - An MC transfer occurs when mc_valid && mc_ready.
  - mc_ready = !full, computed from the occupancy count only. No push into a full FIFO, even when a pop happens in the same cycle.
  - Push and pop in the same cycle are allowed when the FIFO is not full.
- Register 0:
  - A transfer addressed to 0 is consumed but discarded: it is not queued and not written.
  - Reads of address 0 return 0.
- Arbitration, evaluated each cycle:
  - Starve mode = FIFO non-empty && starve count == STARVE_LIMIT.
  - In starve mode: wb_ready = 0 and the FIFO head pops.
  - Otherwise: wb_ready = 1. WB wins if wb_valid; else the FIFO head pops if non-empty.
- Starve counter:
  - Increments when the FIFO is non-empty and no pop occurs.
  - Clears on any pop or when the FIFO is empty.
  - Saturates at STARVE_LIMIT.
- Output stage:
  - The winner is registered into rf_write_*: 1-cycle latency from transfer to rf_write_enable.
  - With no winner, rf_write_enable = 0 and address/data hold.
  - Data is in the bank one edge later.
- Forwarding (combinational), per port, highest priority first:
  - Address 0 returns 0.
  - Else, when wb_valid && wb_ready && address match, return wb_data.
  - Else, when rf_write_enable && address match, return rf_write_data.
  - Else, return rf_read_data.
  - FIFO contents are never forwarded.
- pending_mask: combinational OR of one-hot(address) over valid FIFO entries. Duplicate addresses are allowed.
- waw_error: set, and held until reset, when a WB transfer targets an address whose pending_mask bit is 1. The write itself still proceeds.
- Reset mid-operation: FIFO contents and the output-stage write are dropped; no bank write occurs after reset asserts.

Decomposition:
- Package regfile_arb_pkg holds:
  - the default width constants;
  - the arbitration-source encoding (ARB_NONE, ARB_WB, ARB_MC).
- One sub-module: regfile_write_fifo.
  - Synchronous FIFO, parameters DEPTH and WIDTH = ADDRESS_WIDTH + DATA_WIDTH.
  - Exposes per-entry valid/address vectors for pending_mask.

Test Plan:
- WB write: wb_valid, addr 5, data 0xDEADBEEF at cycle 0 -> rf_write_enable=1, addr 5 at cycle 1. Reading addr 5 returns 0xDEADBEEF at cycle 0 (input forward), at cycle 1 (output-stage forward), and from cycle 2 (bank).
- Contention: WB addr 3 and MC addr 7 in the same cycle -> WB written in cycle 1, MC written in cycle 2. pending_mask bit 7 is set cycles 1-1 and clears when the entry pops.
- Starvation: FIFO holds addr 9; wb_valid held high continuously; STARVE_LIMIT=4 -> wb_ready low in exactly one cycle after 4 lost cycles; addr 9 written the next cycle; WB resumes.
- Backpressure: wb_valid constant, STARVE_LIMIT large, two MC pushes -> mc_ready=0; a third mc_valid is held and not lost; it is accepted after the first pop.
- Register 0: WB addr 0, data 0x1 -> no rf_write_enable; read addr 0 = 0. MC addr 0 -> mc_ready handshake completes; pending_mask stays 0.
- WAW and reset: MC addr 4 queued, then WB addr 4 -> waw_error=1 and stays 1. Assert rst_n low mid-queue -> FIFO empty, waw_error=0, no further rf_write_enable.
